// File: rtl/icache_fill_responder.sv
// icache_fill_responder
//
// SDRAM-side responder for instruction-cache line fills. When the cache asks for a
// line, the block issues LINE_WORDS single-word reads to the SDRAM controller, one
// at a time, and buffers the returned words. Once the whole line is held locally it
// replays it to the cache as one gap-free burst, so controller stalls never show up
// inside the burst.
//
// Ports:
//   sdram_clk    sole clock, rising edge
//   reset        asynchronous, active-high reset
//   icache_ren   level fill request from the cache, held until the first ack
//   icache_addr  word address of the request; only [ADDR_W-1:0] is used, line-aligned
//   sdram_in     line data to the cache, word k on burst cycle k
//   sdram_ack    high for exactly LINE_WORDS consecutive cycles per fill
//   mem_req      read request to the controller, stable until mem_gnt
//   mem_addr     word address of the current read
//   mem_gnt      controller accepted mem_req this cycle
//   mem_rvalid   read data valid
//   mem_rdata    read data
//   busy         high whenever the block is not idle
//
// LINE_WORDS must be a power of two and at least 2.

module icache_fill_responder #(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned ADDR_W     = 21
) (
    input  logic              sdram_clk,
    input  logic              reset,
    input  logic              icache_ren,
    input  logic [31:0]       icache_addr,
    output logic [31:0]       sdram_in,
    output logic              sdram_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int unsigned       OFF_W    = $clog2(LINE_WORDS);
    localparam int unsigned       CNT_W    = OFF_W + 1;
    localparam logic [CNT_W-1:0]  FULL     = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStream,
        StWaitLow,
        StAbort
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  rq_q, rq_d;     // requests granted
    logic [CNT_W-1:0]  rx_q, rx_d;     // words received
    logic [CNT_W-1:0]  tx_q, tx_d;     // index of the word currently on sdram_in
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              outst_q, outst_d;
    logic              ack_q, ack_d;
    logic [31:0]       data_q, data_d;

    logic [31:0]       line_q [LINE_WORDS];
    logic              line_we;
    logic [OFF_W-1:0]  line_idx;
    logic [OFF_W-1:0]  tx_next;

    logic              granted;
    logic              pending;
    logic              accept;

    // Upper request address bits are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^icache_addr[31:ADDR_W];

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        rq_d     = rq_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        req_d    = req_q;
        addr_d   = addr_q;
        outst_d  = outst_q;
        ack_d    = 1'b0;
        data_d   = data_q;
        line_we  = 1'b0;
        line_idx = rx_q[OFF_W-1:0];
        tx_next  = tx_q[OFF_W-1:0] + 1'b1;

        // A grant and its data may land in the same cycle; treat the read as
        // outstanding from the grant onward so both take effect.
        granted = req_q & mem_gnt;
        pending = outst_q | granted;
        accept  = mem_rvalid & pending;

        unique case (state_q)
            StIdle: begin
                if (icache_ren) begin
                    base_d  = icache_addr[ADDR_W-1:0] & ~OFF_MASK;
                    rq_d    = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                    state_d = StFetch;
                end
            end

            StFetch: begin
                outst_d = pending & ~accept;
                if (granted) begin
                    req_d = 1'b0;
                    rq_d  = rq_q + 1'b1;
                end
                if (!icache_ren) begin
                    // Cache gave up: drop any ungranted request, drain the rest.
                    req_d   = 1'b0;
                    state_d = StAbort;
                end else begin
                    if (accept) begin
                        line_we = 1'b1;
                        rx_d    = rx_q + 1'b1;
                    end
                    if (rx_d == FULL) begin
                        // Word 0 is already buffered, so the burst starts right away.
                        state_d = StStream;
                        tx_d    = '0;
                        ack_d   = 1'b1;
                        data_d  = line_q[0];
                    end else if (!req_q && !outst_q && (rq_q < FULL)) begin
                        req_d  = 1'b1;
                        addr_d = base_q + ADDR_W'(rq_q);
                    end
                end
            end

            StStream: begin
                if (tx_q == LAST) begin
                    state_d = StWaitLow;
                end else begin
                    ack_d  = 1'b1;
                    tx_d   = tx_q + 1'b1;
                    data_d = line_q[tx_next];
                end
            end

            StWaitLow: begin
                // A request still held from the finished fill must not restart one.
                if (!icache_ren) begin
                    state_d = StIdle;
                end
            end

            StAbort: begin
                req_d   = 1'b0;
                outst_d = pending & ~accept;
                if (!outst_d) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            rq_q    <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            outst_q <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rq_q    <= rq_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    // Line buffer needs no reset: it is always written before it is read.
    always_ff @(posedge sdram_clk) begin
        if (line_we) begin
            line_q[line_idx] <= mem_rdata;
        end
    end

    assign sdram_in  = data_q;
    assign sdram_ack = ack_q;
    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_icache_fill_responder.sv
// Scoreboard bench for icache_fill_responder. Stimulus pushes the expected read
// addresses and burst words into queues; a controller model pops addresses as it
// grants, and a burst monitor pops words on every ack cycle.

module tb_icache_fill_responder;

    localparam int unsigned ADDR_W = 21;

    logic              clk = 1'b0;
    logic              reset;
    logic              icache_ren;
    logic [31:0]       icache_addr;
    logic [31:0]       sdram_in;
    logic              sdram_ack;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              busy;

    always #5 clk = ~clk;

    icache_fill_responder #(
        .LINE_WORDS(16),
        .ADDR_W    (ADDR_W)
    ) dut (
        .sdram_clk  (clk),
        .reset      (reset),
        .icache_ren (icache_ren),
        .icache_addr(icache_addr),
        .sdram_in   (sdram_in),
        .sdram_ack  (sdram_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0]       exp_data [$];
    logic [ADDR_W-1:0] exp_addr [$];

    int gnt_cnt   = 0;
    int rv_cnt    = 0;
    int mon_words = 0;
    int min_gd    = 0;
    int max_gd    = 0;
    int min_rd    = 0;
    int max_rd    = 0;

    // Controller model state
    logic              req_seen   = 1'b0;
    logic              rd_pending = 1'b0;
    int                gnt_wait   = 0;
    int                rd_wait    = 0;
    logic [ADDR_W-1:0] req_addr   = '0;
    logic [ADDR_W-1:0] rd_addr    = '0;

    // Monitor state
    int          run       = 0;
    logic [31:0] last_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s: %s at %0t", name, detail, $time);
    endtask

    // SDRAM controller model: random grant and data latency, data = addr ^ 0xA5A5_0000.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (reset) begin
                req_seen   = 1'b0;
                rd_pending = 1'b0;
            end else if (rd_pending) begin
                chk("one_outstanding", 32'(mem_req), 32'd0);
                if (rd_wait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = {11'b0, rd_addr} ^ 32'hA5A5_0000;
                    rd_pending = 1'b0;
                    rv_cnt++;
                end else begin
                    rd_wait--;
                end
            end else if (mem_req) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    req_addr = mem_addr;
                    gnt_wait = int'($urandom_range(max_gd, min_gd));
                end else begin
                    chk("req_addr_stable", 32'(mem_addr), 32'(req_addr));
                end
                if (gnt_wait == 0) begin
                    mem_gnt    = 1'b1;
                    req_seen   = 1'b0;
                    rd_pending = 1'b1;
                    rd_addr    = req_addr;
                    rd_wait    = int'($urandom_range(max_rd, min_rd));
                    gnt_cnt++;
                    if (exp_addr.size() == 0)
                        note_fail("unexpected_read", $sformatf("got addr 0x%06h, required none", mem_addr));
                    else
                        chk("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                end else begin
                    gnt_wait--;
                end
            end else begin
                req_seen = 1'b0;
            end
        end
    end

    // Burst monitor: every ack cycle must carry the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
            end else if (sdram_ack) begin
                run++;
                mon_words++;
                if (exp_data.size() == 0) begin
                    note_fail("ack_unexpected", $sformatf("got ack data 0x%08h, required no ack", sdram_in));
                end else begin
                    last_word = exp_data.pop_front();
                    chk("burst_word", sdram_in, last_word);
                end
            end else if (run != 0) begin
                chk("burst_len", 32'(run), 32'd16);
                chk("data_hold", sdram_in, last_word);
                run = 0;
            end
        end
    end

    task automatic push_line(input logic [31:0] addr, input bit with_data);
        logic [ADDR_W-1:0] base;
        base = addr[ADDR_W-1:0] & ~21'h0000F;
        for (int i = 0; i < 16; i++) begin
            exp_addr.push_back(base + 21'(i));
            if (with_data) exp_data.push_back({11'b0, base + 21'(i)} ^ 32'hA5A5_0000);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) note_fail("idle_timeout", "got busy=1, required busy=0");
    endtask

    task automatic do_fill(input logic [31:0] addr, input bit check_lat, input int hold);
        int lat;
        int n;
        wait_idle();
        push_line(addr, 1'b1);
        icache_addr = addr;
        icache_ren  = 1'b1;
        @(posedge clk);
        #1;
        chk("req_after_N", 32'(mem_req), 32'd0);
        chk("busy_after_N", 32'(busy), 32'd1);
        lat = 0;
        while (!sdram_ack && lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) chk("req_after_N1", 32'(mem_req), 32'd1);
        end
        if (!sdram_ack) note_fail("ack_timeout", $sformatf("got no ack after %0d cycles", lat));
        else if (check_lat) chk("fill_latency", 32'(lat), 32'd48);
        if (hold == 0) icache_ren = 1'b0;
        n = 0;
        while ((sdram_ack || exp_data.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) note_fail("burst_end_timeout", "got burst still running, required end");
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                #1;
                chk("held_no_req", 32'(mem_req), 32'd0);
                chk("held_busy", 32'(busy), 32'd1);
            end
            icache_ren = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int g0;
        int r0;
        int n;
        int target;

        reset       = 1'b1;
        icache_ren  = 1'b0;
        icache_addr = '0;
        #12;
        chk("rst_ack", 32'(sdram_ack), 32'd0);
        chk("rst_data", sdram_in, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic fill, zero-wait controller
        do_fill(32'h0000_0127, 1'b1, 0);

        // Stalled controller; upper address bits must be ignored
        min_gd = 0; max_gd = 7; min_rd = 0; max_rd = 7;
        do_fill(32'h3456_7A89, 1'b0, 0);
        do_fill(32'h0000_0A50, 1'b0, 0);
        min_gd = 0; max_gd = 0; min_rd = 0; max_rd = 0;

        // Held request: exactly one fill
        do_fill(32'h0000_0200, 1'b1, 5);

        // Abort with the sixth read outstanding
        wait_idle();
        min_rd = 3; max_rd = 3;
        g0 = gnt_cnt;
        r0 = rv_cnt;
        push_line(32'h0000_0300, 1'b0);
        icache_addr = 32'h0000_0300;
        icache_ren  = 1'b1;
        n = 0;
        while (gnt_cnt < g0 + 6 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        icache_ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_drain_busy", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_grants", 32'(gnt_cnt - g0), 32'd6);
        chk("abort_reads_done", 32'(rv_cnt - r0), 32'd6);
        exp_addr.delete();
        min_rd = 0; max_rd = 0;

        // Reset in the middle of the burst, with word 7 on the bus
        wait_idle();
        push_line(32'h0000_0500, 1'b1);
        icache_addr = 32'h0000_0500;
        icache_ren  = 1'b1;
        target = mon_words + 8;
        n = 0;
        while (mon_words < target && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (mon_words < target) note_fail("stream_timeout", "got too few burst words before reset");
        reset = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(sdram_ack), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        icache_ren = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        do_fill(32'h0000_0040, 1'b1, 0);

        // Back-to-back fills, top line of the address space first
        do_fill(32'h001F_FFF0, 1'b1, 0);
        do_fill(32'h0000_0010, 1'b1, 0);

        wait_idle();
        chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        chk("data_queue_drained", 32'(exp_data.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
